xcel_mem_arbiter: RTL
=====================

Name: xcel_mem_arbiter

Overview:
- Shares the single memory request/response stream between two sorting-accelerator engines, for example two partition units working on disjoint subarrays.
- Req 0 / req 1 arbitration is round-robin.
- Each granted requester's index is recorded in an in-order tag FIFO, and each memory response is routed back to the requester that issued it.
- Sits between the engines and the memory port of the accelerator wrapper.

Parameters:
- p_max_outstanding, 4: depth of the tag FIFO, i.e. the maximum number of in-flight memory requests. Power of two, ≥ 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req0_reqstream_msg  input  mem_req_4B_t  requester 0 memory request
- req0_reqstream_val  input  1  requester 0 request valid
- req0_reqstream_rdy  output  1  requester 0 request ready
- req0_respstream_msg  output  mem_resp_4B_t  requester 0 response
- req0_respstream_val  output  1  requester 0 response valid
- req0_respstream_rdy  input  1  requester 0 response ready
- req1_*  (same six ports as req0_*)  requester 1
- mem_reqstream_msg  output  mem_req_4B_t  request to memory
- mem_reqstream_val  output  1  request valid
- mem_reqstream_rdy  input  1  memory ready
- mem_respstream_msg  input  mem_resp_4B_t  response from memory
- mem_respstream_val  input  1  response valid
- mem_respstream_rdy  output  1  response ready

Behaviour:
- **Handshake:** val/rdy; a transfer fires when val && rdy on the same rising edge.
- **Reset:** reset low asynchronously clears all state:
  - priority pointer = 0;
  - tag FIFO empty: head = tail = 0, count = 0.
  - While reset is held, all outputs are low.
  - Reset mid-operation discards in-flight tags; memory must be reset together with this block.
- **Request path:** combinational, 0-cycle latency.
  - can_issue = (count < p_max_outstanding).
  - grant = requester that has val=1. If both are valid, grant goes to the one selected by the priority pointer.
  - mem_reqstream_val = can_issue && (req0_val || req1_val).
  - mem_reqstream_msg = the granted requester's msg, passed unmodified (opaque field untouched).
  - reqN_reqstream_rdy = can_issue && mem_reqstream_rdy && (grant == N).
- **Priority pointer:** on a request fire, the pointer becomes !grant. With no fire it holds.
  - Result: both requesters continuously valid and memory always ready → grants alternate 0,1,0,1...
- **Tag FIFO:** 1-bit entries, circular, with log2(p_max_outstanding) pointers that wrap.
  - Push: the grant index, on a memory request fire.
  - Pop: on a memory response fire.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full (count == p_max_outstanding): no request is issued, even if a pop occurs in that cycle (no full bypass).
- **Response path:** combinational. Memory returns responses in request order.
  - Let head tag = H.
  - When count > 0:
    - reqH_respstream_val = mem_respstream_val;
    - reqH_respstream_msg = mem_respstream_msg;
    - mem_respstream_rdy = reqH_respstream_rdy;
    - the other requester's respstream_val = 0.
  - When the FIFO is empty: mem_respstream_rdy = 0 and both respstream_val = 0. A stray response stalls; it is never dropped.
  - respstream_msg on a non-selected port is don't-care; drive it with mem_respstream_msg.
- **Back-pressure:** a stalled head-of-line response blocks all later responses, which is correct because memory is in order. Requests continue to issue until the FIFO is full.
- **Line trace:** the line trace shows the grant index, count, and head tag.

Optional Feature:
- **Macro:** XCEL_MEM_ARB_STATS_EN.
- **When defined**, three extra outputs are added:
  - grant0_count (32), grant1_count (32), conflict_count (32).
  - grantN_count increments on each request fire granted to N.
  - conflict_count increments on each cycle where both reqN_reqstream_val = 1 and can_issue && mem_reqstream_rdy.
  - All three reset to 0 with reset low and wrap modulo 2^32.
- **When undefined**, these ports and counters do not exist, and the other behaviour is identical.

Test Plan:
- Only req0 valid, 3 reads to addr 0x1000/0x1004/0x1008, memory 1-cycle latency → 3 memory requests in order; req0 receives 3 responses with matching data; req1_respstream_val stays 0.
- Both valid for 6 cycles, memory always ready → memory sees grants 0,1,0,1,0,1; each response is returned to its issuer.
- Memory stalls responses with p_max_outstanding=4, both valid → exactly 4 requests issue, then both reqstream_rdy = 0 until the first response fires, after which one request issues.
- req0's response arrives first but req0_respstream_rdy = 0 for 5 cycles → mem_respstream_rdy = 0 for those 5 cycles; req1's later response is not delivered before req0's.
- Reset driven low while 2 requests are in flight, memory reset too → all val/rdy outputs low immediately, count = 0, pointer = 0; the first request after reset goes to req0 when both are valid.
- STATS_EN: 4 alternating contested grants → grant0_count = 2, grant1_count = 2, conflict_count = 4.

Source files
------------

// File: rtl/xcel_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between two engines; 0-cycle request/response paths.
// Back-pressure: requests stall when the tag FIFO is full; a stalled head response blocks later ones. Optional stats: XCEL_MEM_ARB_STATS_EN.
package xcel_mem_arbiter_pkg;
    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;
endpackage

module xcel_mem_arbiter
    import xcel_mem_arbiter_pkg::*;
#(
    parameter int p_max_outstanding = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  mem_req_4B_t  req0_reqstream_msg,
    input  logic         req0_reqstream_val,
    output logic         req0_reqstream_rdy,
    output mem_resp_4B_t req0_respstream_msg,
    output logic         req0_respstream_val,
    input  logic         req0_respstream_rdy,
    input  mem_req_4B_t  req1_reqstream_msg,
    input  logic         req1_reqstream_val,
    output logic         req1_reqstream_rdy,
    output mem_resp_4B_t req1_respstream_msg,
    output logic         req1_respstream_val,
    input  logic         req1_respstream_rdy,
    output mem_req_4B_t  mem_reqstream_msg,
    output logic         mem_reqstream_val,
    input  logic         mem_reqstream_rdy,
    input  mem_resp_4B_t mem_respstream_msg,
    input  logic         mem_respstream_val,
    output logic         mem_respstream_rdy
`ifdef XCEL_MEM_ARB_STATS_EN
    ,
    output logic [31:0]  grant0_count,
    output logic [31:0]  grant1_count,
    output logic [31:0]  conflict_count
`endif
);
    localparam int PW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam int CW = PW + 1;

    logic [p_max_outstanding-1:0] r_tags;
    logic [PW-1:0]                r_head;
    logic [PW-1:0]                r_tail;
    logic [CW-1:0]                r_count;
    logic                         r_ptr;

    logic w_can_issue;
    logic w_both_val;
    logic w_grant;
    logic w_req_fire;
    logic w_nonempty;
    logic w_head_tag;
    logic w_resp_fire;

    assign w_can_issue = (r_count < CW'(p_max_outstanding));
    assign w_both_val  = req0_reqstream_val && req1_reqstream_val;
    assign w_grant     = w_both_val ? r_ptr : req1_reqstream_val;

    // Every output is forced low while reset is asserted, including the pass-through payloads.
    assign mem_reqstream_val  = reset && w_can_issue && (req0_reqstream_val || req1_reqstream_val);
    assign mem_reqstream_msg  = reset ? (w_grant ? req1_reqstream_msg : req0_reqstream_msg) : '0;
    assign req0_reqstream_rdy = reset && w_can_issue && mem_reqstream_rdy && !w_grant;
    assign req1_reqstream_rdy = reset && w_can_issue && mem_reqstream_rdy && w_grant;
    assign w_req_fire         = mem_reqstream_val && mem_reqstream_rdy;

    assign w_nonempty  = (r_count != '0);
    assign w_head_tag  = r_tags[r_head];

    assign req0_respstream_val = reset && w_nonempty && !w_head_tag && mem_respstream_val;
    assign req1_respstream_val = reset && w_nonempty && w_head_tag && mem_respstream_val;
    assign req0_respstream_msg = reset ? mem_respstream_msg : '0;
    assign req1_respstream_msg = reset ? mem_respstream_msg : '0;
    // With no tag outstanding a response has no owner, so it is held off rather than dropped.
    assign mem_respstream_rdy  = reset && w_nonempty &&
                                 (w_head_tag ? req1_respstream_rdy : req0_respstream_rdy);
    assign w_resp_fire         = mem_respstream_val && mem_respstream_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tags  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ptr   <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_tags[r_tail] <= w_grant;
                r_tail         <= r_tail + PW'(1);
                r_ptr          <= ~w_grant;
            end
            if (w_resp_fire) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef XCEL_MEM_ARB_STATS_EN
    logic [31:0] r_grant0_count;
    logic [31:0] r_grant1_count;
    logic [31:0] r_conflict_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant0_count   <= '0;
            r_grant1_count   <= '0;
            r_conflict_count <= '0;
        end else begin
            if (w_req_fire && !w_grant) r_grant0_count <= r_grant0_count + 32'd1;
            if (w_req_fire && w_grant)  r_grant1_count <= r_grant1_count + 32'd1;
            if (w_both_val && w_can_issue && mem_reqstream_rdy) begin
                r_conflict_count <= r_conflict_count + 32'd1;
            end
        end
    end

    assign grant0_count   = r_grant0_count;
    assign grant1_count   = r_grant1_count;
    assign conflict_count = r_conflict_count;
`endif

`ifndef SYNTHESIS
    function automatic string line_trace();
        return $sformatf("g%0d c%0d h%0d", w_grant, r_count, w_head_tag);
    endfunction
`endif

endmodule
